// File: rtl/snake_pkg.sv
// snake_pkg -- shared encodings and dimensions for the snake game blocks.
//   MODE_* : values of the mode bus seen by the apple-placement and body blocks
//   state_t: game sequencer states
//   LEN_W / DIV_W / FIELD_*: shared widths and playfield size
package snake_pkg;

   localparam int MODE_W = 2;
   localparam logic [MODE_W-1:0] MODE_IDLE = 2'd0;
   localparam logic [MODE_W-1:0] MODE_PLAY = 2'd1;
   localparam logic [MODE_W-1:0] MODE_OVER = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY,
      S_PAUSE,
      S_OVER
   } state_t;

   // Snake length bus width and tick-counter width (12.5M fits in 24 bits).
   localparam int LEN_W = 7;
   localparam int DIV_W = 24;

   // Playfield in cells; the body and apple blocks size their coordinates from these.
   localparam int FIELD_W   = 32;
   localparam int FIELD_H   = 24;
   localparam int FIELD_X_W = $clog2(FIELD_W);
   localparam int FIELD_Y_W = $clog2(FIELD_H);

endpackage

// File: rtl/snake_game_ctrl_if.sv
// snake_game_ctrl_if -- game-control bundle between the sequencer and its peers.
//   master: drives buttons and playfield flags, observes game outputs
//   slave : the sequencer (snake_game_ctrl)
//   inputs to sequencer : start_btn, pause_btn, eat_in, hit_wall, hit_body
//   outputs of sequencer: mode[1:0], paused, move_tick, grow, score[SCORE_W], length[7]
interface snake_game_ctrl_if #(
   parameter int SCORE_W = 8
);
   import snake_pkg::*;

   logic                 start_btn;
   logic                 pause_btn;
   logic                 eat_in;
   logic                 hit_wall;
   logic                 hit_body;
   logic [MODE_W-1:0]    mode;
   logic                 paused;
   logic                 move_tick;
   logic                 grow;
   logic [SCORE_W-1:0]   score;
   logic [LEN_W-1:0]     length;

   modport master (
      output start_btn, pause_btn, eat_in, hit_wall, hit_body,
      input  mode, paused, move_tick, grow, score, length
   );

   modport slave (
      input  start_btn, pause_btn, eat_in, hit_wall, hit_body,
      output mode, paused, move_tick, grow, score, length
   );

endinterface

// File: rtl/tick_divider.sv
// tick_divider -- move-tick generator.
//   clk_50MHz, rst_n : clock, async active-low reset
//   enable           : count this cycle (low holds the counter, no tick)
//   clear            : reset counter to 0 (wins over enable)
//   div              : period in cycles; tick fires when counter reaches div-1
//   tick             : registered one-cycle strobe
// The wrap compare is >= so that a period shortened below the current count
// wraps on the next enabled cycle instead of running off to 2^DIV_W.
module tick_divider
   import snake_pkg::*;
(
   input  logic             clk_50MHz,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         if (cnt_q >= div - 1'b1) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl -- top-level snake game sequencer.
//   clk_50MHz : system clock
//   rst_n     : async active-low reset
//   bus       : snake_game_ctrl_if.slave (buttons, eat/hit flags in; mode,
//               paused, move_tick, grow, score, length out; all registered)
// Build option: SNAKE_SPEEDUP_EN -- shortens the move period by SPEED_STEP
// every 4 apples down to MIN_DIV. Without it the period is fixed at TICK_DIV.
//
// state   | meaning
// S_IDLE  | waiting for start, mode=IDLE (apple at home)
// S_PLAY  | game running, move ticks issued, eats counted
// S_PAUSE | frozen, mode stays PLAY, counter held, eat/hit ignored
// S_OVER  | collision seen, score/length frozen until start
module snake_game_ctrl
   import snake_pkg::*;
#(
   parameter int TICK_DIV   = 12_500_000,
   parameter int INIT_LEN   = 3,
   parameter int MAX_LEN    = 64,
   parameter int SCORE_W    = 8
`ifdef SNAKE_SPEEDUP_EN
   ,
   parameter int MIN_DIV    = 3_125_000,
   parameter int SPEED_STEP = 1_250_000
`endif
) (
   input  logic                clk_50MHz,
   input  logic                rst_n,
   snake_game_ctrl_if.slave    bus
);

   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   state_t              state_q;
   logic [MODE_W-1:0]   mode_q;
   logic                paused_q;
   logic                grow_q;
   logic [SCORE_W-1:0]  score_q;
   logic [LEN_W-1:0]    len_q;
   logic                eat_prev_q;

   logic                collide;
   logic                eat_edge;
   logic                play_entry;
   logic                div_en;
   logic                move_tick;
   logic [DIV_W-1:0]    cur_div;

   assign collide    = bus.hit_wall | bus.hit_body;
   assign eat_edge   = bus.eat_in & ~eat_prev_q;
   assign play_entry = (state_q == S_IDLE) && bus.start_btn;
   // Counting stops in the cycle a pause or collision is taken, so no tick
   // leaks out on the transition and a resume continues from the same count.
   assign div_en     = (state_q == S_PLAY) && !collide && !bus.pause_btn;

   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mode_q     <= MODE_IDLE;
         paused_q   <= 1'b0;
         grow_q     <= 1'b0;
         score_q    <= '0;
         len_q      <= LEN_W'(INIT_LEN);
         eat_prev_q <= 1'b0;
      end else begin
         eat_prev_q <= bus.eat_in;
         grow_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start_btn) begin
                  state_q <= S_PLAY;
                  mode_q  <= MODE_PLAY;
                  score_q <= '0;
                  len_q   <= LEN_W'(INIT_LEN);
               end
            end
            S_PLAY: begin
               if (collide) begin
                  state_q <= S_OVER;
                  mode_q  <= MODE_OVER;
               end else begin
                  if (bus.pause_btn) begin
                     state_q  <= S_PAUSE;
                     paused_q <= 1'b1;
                  end
                  if (eat_edge) begin
                     grow_q <= 1'b1;
                     if (score_q != SCORE_MAX) score_q <= score_q + 1'b1;
                     if (len_q < LEN_W'(MAX_LEN)) len_q <= len_q + 1'b1;
                  end
               end
            end
            S_PAUSE: begin
               if (bus.pause_btn) begin
                  state_q  <= S_PLAY;
                  paused_q <= 1'b0;
               end
            end
            S_OVER: begin
               if (bus.start_btn) begin
                  state_q <= S_IDLE;
                  mode_q  <= MODE_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               mode_q  <= MODE_IDLE;
            end
         endcase
      end
   end

`ifdef SNAKE_SPEEDUP_EN
   logic             score_inc;
   logic [DIV_W-1:0] cur_div_q;

   assign score_inc = (state_q == S_PLAY) && eat_edge && !collide &&
                      (score_q != SCORE_MAX);

   // Old score[1:0]==3 means the new score is a multiple of 4.
   always_ff @(posedge clk_50MHz or negedge rst_n) begin
      if (!rst_n) begin
         cur_div_q <= DIV_W'(TICK_DIV);
      end else if (play_entry) begin
         cur_div_q <= DIV_W'(TICK_DIV);
      end else if (score_inc && (score_q[1:0] == 2'b11)) begin
         if (cur_div_q >= DIV_W'(MIN_DIV + SPEED_STEP))
            cur_div_q <= cur_div_q - DIV_W'(SPEED_STEP);
         else
            cur_div_q <= DIV_W'(MIN_DIV);
      end
   end

   assign cur_div = cur_div_q;
`else
   assign cur_div = DIV_W'(TICK_DIV);
`endif

   tick_divider u_tick_divider (
      .clk_50MHz (clk_50MHz),
      .rst_n     (rst_n),
      .enable    (div_en),
      .clear     (play_entry),
      .div       (cur_div),
      .tick      (move_tick)
   );

   assign bus.mode      = mode_q;
   assign bus.paused    = paused_q;
   assign bus.move_tick = move_tick;
   assign bus.grow      = grow_q;
   assign bus.score     = score_q;
   assign bus.length    = len_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// tb_snake_game_ctrl -- directed bench for snake_game_ctrl with a short
// move period (TICK_DIV=8). Cycle numbers below count from the edge that
// samples start_btn (cycle 0); cycle 1 is the first cycle in PLAY.
module tb_snake_game_ctrl;

   logic clk_50MHz;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   cyc;
   int   per;

   snake_game_ctrl_if #(.SCORE_W(8)) bus ();

   snake_game_ctrl #(
      .TICK_DIV   (8),
      .INIT_LEN   (3),
      .MAX_LEN    (64),
      .SCORE_W    (8)
`ifdef SNAKE_SPEEDUP_EN
      ,
      .MIN_DIV    (4),
      .SPEED_STEP (2)
`endif
   ) dut (
      .clk_50MHz (clk_50MHz),
      .rst_n     (rst_n),
      .bus       (bus)
   );

   initial clk_50MHz = 1'b0;
   always #5 clk_50MHz = ~clk_50MHz;

   task automatic step();
      @(posedge clk_50MHz);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Cycles from one move_tick to the next, bounded at 64 per wait.
   task automatic measure(output int p);
      int n;
      n = 0;
      while (bus.move_tick !== 1'b1 && n < 64) begin
         step();
         n++;
      end
      p = 0;
      do begin
         step();
         p++;
      end while (bus.move_tick !== 1'b1 && p < 64);
   endtask

   task automatic eat_once();
      bus.eat_in = 1'b1;
      step();
      bus.eat_in = 1'b0;
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mode"},   bus.mode, 0);
      check({tag, "_paused"}, bus.paused, 0);
      check({tag, "_tick"},   bus.move_tick, 0);
      check({tag, "_grow"},   bus.grow, 0);
      check({tag, "_score"},  bus.score, 0);
      check({tag, "_length"}, bus.length, 3);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.start_btn = 1'b0;
      bus.pause_btn = 1'b0;
      bus.eat_in    = 1'b0;
      bus.hit_wall  = 1'b0;
      bus.hit_body  = 1'b0;

      #12;
      check_reset_outputs("rst");
      #10 rst_n = 1'b1;
      step();
      check("idle_mode", bus.mode, 0);

      // Game 1: start, then tick pattern at 9, 17, 25.
      bus.start_btn = 1'b1;
      step();
      bus.start_btn = 1'b0;
      cyc = 1;
      check("start_mode", bus.mode, 1);
      check("start_len", bus.length, 3);
      check("start_score", bus.score, 0);
      repeat (27) begin
         check("tick_run", bus.move_tick, (cyc == 9 || cyc == 17 || cyc == 25));
         step();
         cyc++;
      end

      // Cycle 28, counter 3: pause for 20 cycles, hit/eat ignored meanwhile.
      bus.pause_btn = 1'b1;
      step();
      bus.pause_btn = 1'b0;
      cyc = 29;
      repeat (20) begin
         check("pause_paused", bus.paused, 1);
         check("pause_mode", bus.mode, 1);
         check("pause_tick", bus.move_tick, 0);
         bus.hit_wall  = (cyc == 35);
         bus.eat_in    = (cyc == 36 || cyc == 37);
         bus.pause_btn = (cyc == 48);
         step();
         cyc++;
      end
      bus.hit_wall  = 1'b0;
      bus.eat_in    = 1'b0;
      bus.pause_btn = 1'b0;
      check("pause_score", bus.score, 0);
      // Resumed at cycle 49 with counter 3: next tick at 54.
      repeat (6) begin
         check("resume_paused", bus.paused, 0);
         check("resume_tick", bus.move_tick, (cyc == 54));
         step();
         cyc++;
      end

      // eat_in high for 3 cycles gives one grow.
      for (int k = 0; k < 5; k++) begin
         bus.eat_in = (k < 3);
         step();
         check("grow_once", bus.grow, (k == 0));
      end
      bus.eat_in = 1'b0;
      check("eat1_score", bus.score, 1);
      check("eat1_len", bus.length, 4);

      // 70 more eats: length saturates at 64, grow still pulses.
      repeat (70) begin
         bus.eat_in = 1'b1;
         step();
         check("grow_each", bus.grow, 1);
         bus.eat_in = 1'b0;
         step();
      end
      check("sat_score", bus.score, 71);
      check("sat_len", bus.length, 64);

      // Eat edge together with hit_body: collision wins.
      bus.eat_in   = 1'b1;
      bus.hit_body = 1'b1;
      step();
      bus.eat_in   = 1'b0;
      bus.hit_body = 1'b0;
      check("coll_mode", bus.mode, 2);
      check("coll_score", bus.score, 71);
      check("coll_len", bus.length, 64);
      check("coll_grow", bus.grow, 0);

      bus.start_btn = 1'b1;
      step();
      bus.start_btn = 1'b0;
      check("over_idle_mode", bus.mode, 0);
      check("over_idle_score", bus.score, 71);

      // start and pause together in IDLE: start wins, game 2 cycle 1.
      bus.start_btn = 1'b1;
      bus.pause_btn = 1'b1;
      step();
      bus.start_btn = 1'b0;
      bus.pause_btn = 1'b0;
      check("g2_mode", bus.mode, 1);
      check("g2_paused", bus.paused, 0);
      check("g2_score", bus.score, 0);
      check("g2_len", bus.length, 3);
      repeat (7) step();
      check("g2_c8_tick", bus.move_tick, 0);
      // Collision on the cycle that would have wrapped: no tick.
      bus.hit_wall = 1'b1;
      step();
      bus.hit_wall = 1'b0;
      check("g2_over_mode", bus.mode, 2);
      check("g2_over_tick", bus.move_tick, 0);
      step();
      check("g2_over_tick2", bus.move_tick, 0);
      check("g2_over_mode2", bus.mode, 2);

`ifdef SNAKE_SPEEDUP_EN
      bus.start_btn = 1'b1;
      step();
      step();
      bus.start_btn = 1'b0;
      check("spd_mode", bus.mode, 1);
      measure(per);
      check("spd_p0", per, 8);
      repeat (4) eat_once();
      measure(per);
      check("spd_p4", per, 6);
      repeat (4) eat_once();
      measure(per);
      check("spd_p8", per, 4);
      repeat (4) eat_once();
      measure(per);
      check("spd_p12", per, 4);
      check("spd_score", bus.score, 12);
      bus.hit_wall = 1'b1;
      step();
      bus.hit_wall = 1'b0;
      check("spd_over", bus.mode, 2);
`endif

      // Asynchronous reset while paused mid-game.
      bus.start_btn = 1'b1;
      step();
      step();
      bus.start_btn = 1'b0;
      eat_once();
      bus.pause_btn = 1'b1;
      step();
      bus.pause_btn = 1'b0;
      check("pre_rst_paused", bus.paused, 1);
      check("pre_rst_score", bus.score, 1);
      check("pre_rst_len", bus.length, 4);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      #2 rst_n = 1'b1;
      step();
      check("post_rst_mode", bus.mode, 0);
      bus.start_btn = 1'b1;
      step();
      bus.start_btn = 1'b0;
      check("post_rst_start", bus.mode, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
